// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//
// Oversampling UART receiver with 16550-style framing options. The serial
// line is synchronised, each bit is decided by a three-sample majority vote
// around mid-bit, and completed frames are presented on a valid/ready output
// register together with parity, framing and break status.
//
// Parameters
//   OVERSAMPLE   baud_pulse ticks per bit period (even, >= 8)
//   SYNC_STAGES  synchroniser flops on rx (>= 2)
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-low reset
//   baud_pulse     one-clk oversample tick; all bit timing advances on it
//   rx             asynchronous serial input, idle high
//   wls[1:0]       word length: 00=5, 01=6, 10=7, 11=8 data bits
//   pen            parity enable
//   eps            even parity select
//   sticky_parity  stick parity (parity bit forced to ~eps)
//   stb            0 = one stop bit, 1 = two stop bits
//   ready          consumer accepts the held frame
//   valid          a frame is held on dout/pe/fe/bi
//   dout[7:0]      received data, zero-extended above the word length
//   pe, fe, bi     parity error, framing error, break indication
//   overrun        one-clk pulse: a completed frame was dropped
//   state_dbg[2:0] current receiver state, for observation only
//
// Output handshake: a frame is transferred on every rising clk edge where
// valid && ready. valid rises the clk after a frame completes and falls the
// clk after the transfer, unless a new frame completes on that same clk, in
// which case valid stays high and the new frame replaces the old one. While
// valid is high dout/pe/fe/bi do not change. A frame that completes while
// valid && !ready is discarded and signalled on overrun.
// -----------------------------------------------------------------------------
module uart_rx_param #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic       rx,
   input  logic [1:0] wls,
   input  logic       pen,
   input  logic       eps,
   input  logic       sticky_parity,
   input  logic       stb,
   input  logic       ready,
   output logic       valid,
   output logic [7:0] dout,
   output logic       pe,
   output logic       fe,
   output logic       bi,
   output logic       overrun,
   output logic [2:0] state_dbg
);

   localparam int CW = $clog2(OVERSAMPLE);

   // Tick positions within one bit period.
   localparam logic [CW-1:0] CNT_SAMPLE_A = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_SAMPLE_B = CW'(OVERSAMPLE / 2);
   localparam logic [CW-1:0] CNT_DECIDE   = CW'(OVERSAMPLE / 2 + 1);
   localparam logic [CW-1:0] CNT_LAST     = CW'(OVERSAMPLE - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_START    = 3'd1;
   localparam logic [2:0] S_DATA     = 3'd2;
   localparam logic [2:0] S_PARITY   = 3'd3;
   localparam logic [2:0] S_STOP     = 3'd4;
   localparam logic [2:0] S_BRK_WAIT = 3'd5;

   // Synchroniser and post-reset arming.
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES-1:0] fill_q, fill_d;
   logic                   armed_q, armed_d;
   logic                   rs;

   // Receiver state.
   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic          samp_a_q, samp_a_d;
   logic          samp_b_q, samp_b_d;
   logic [7:0]    data_q, data_d;
   logic          par_bit_q, par_bit_d;
   logic          pe_calc_q, pe_calc_d;
   logic          second_q, second_d;

   // Per-frame configuration captured when the start bit is accepted.
   logic [1:0] cfg_wls_q, cfg_wls_d;
   logic       cfg_pen_q, cfg_pen_d;
   logic       cfg_eps_q, cfg_eps_d;
   logic       cfg_sp_q, cfg_sp_d;
   logic       cfg_stb_q, cfg_stb_d;

   // Output holding register.
   logic       valid_q, valid_d;
   logic [7:0] dout_q, dout_d;
   logic       pe_q, pe_d;
   logic       fe_q, fe_d;
   logic       bi_q, bi_d;
   logic       overrun_q, overrun_d;

   // Decisions produced by the bit FSM for the output register.
   logic maj;
   logic exp_par;
   logic complete;
   logic brk;
   logic stop_bit;

   assign rs = sync_q[SYNC_STAGES-1];

   // -------------------------------------------------------------------------
   // Synchroniser. fill_q tracks how many real rx samples have entered the
   // chain since reset; the receiver only arms once the synchronised line has
   // been seen high, so a start edge that predates reset release is ignored.
   // -------------------------------------------------------------------------
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
      fill_d  = {fill_q[SYNC_STAGES-2:0], 1'b1};
      armed_d = armed_q;
      if (fill_q[SYNC_STAGES-1] && rs) begin
         armed_d = 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Bit FSM
   // -------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      samp_a_d  = samp_a_q;
      samp_b_d  = samp_b_q;
      data_d    = data_q;
      par_bit_d = par_bit_q;
      pe_calc_d = pe_calc_q;
      second_d  = second_q;
      cfg_wls_d = cfg_wls_q;
      cfg_pen_d = cfg_pen_q;
      cfg_eps_d = cfg_eps_q;
      cfg_sp_d  = cfg_sp_q;
      cfg_stb_d = cfg_stb_q;
      complete  = 1'b0;
      brk       = 1'b0;
      stop_bit  = 1'b1;

      // Third sample is the live rs at the decision tick.
      maj = (samp_a_q & samp_b_q) | (samp_a_q & rs) | (samp_b_q & rs);

      // Parity the transmitter should have sent. data_q is zero above the
      // word length, so reducing over all eight bits is exact.
      if (cfg_sp_q) begin
         exp_par = ~cfg_eps_q;
      end else if (cfg_eps_q) begin
         exp_par = ^data_q;
      end else begin
         exp_par = ~(^data_q);
      end

      if (baud_pulse) begin
         if (cnt_q == CNT_SAMPLE_A) begin
            samp_a_d = rs;
         end
         if (cnt_q == CNT_SAMPLE_B) begin
            samp_b_d = rs;
         end

         case (state_q)
            S_IDLE: begin
               cnt_d = '0;
               if (armed_q && !rs) begin
                  state_d = S_START;
               end
            end

            S_START: begin
               if (cnt_q == CNT_DECIDE && maj) begin
                  // Line went back high: noise, not a start bit.
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d   = S_DATA;
                  cnt_d     = '0;
                  idx_d     = 3'd0;
                  data_d    = 8'h00;
                  pe_calc_d = 1'b0;
                  par_bit_d = 1'b0;
                  cfg_wls_d = wls;
                  cfg_pen_d = pen;
                  cfg_eps_d = eps;
                  cfg_sp_d  = sticky_parity;
                  cfg_stb_d = stb;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            S_DATA: begin
               if (cnt_q == CNT_DECIDE) begin
                  data_d[idx_q] = maj;
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  // Last data bit index is word length - 1 = wls + 4.
                  if (idx_q == ({1'b0, cfg_wls_q} + 3'd4)) begin
                     state_d  = cfg_pen_q ? S_PARITY : S_STOP;
                     second_d = 1'b0;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            S_PARITY: begin
               if (cnt_q == CNT_DECIDE) begin
                  par_bit_d = maj;
                  pe_calc_d = (maj != exp_par);
               end
               if (cnt_q == CNT_LAST) begin
                  state_d = S_STOP;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            S_STOP: begin
               if (cnt_q == CNT_DECIDE && !second_q) begin
                  // Frame completes at the first stop bit decision; a second
                  // stop bit is only timed.
                  complete = 1'b1;
                  stop_bit = maj;
                  brk      = (data_q == 8'h00) && (!cfg_pen_q || !par_bit_q) && !maj;
                  if (brk) begin
                     state_d = S_BRK_WAIT;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  if (cfg_stb_q && !second_q) begin
                     second_d = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            S_BRK_WAIT: begin
               // One report per break: hold here until the line recovers.
               cnt_d = '0;
               if (rs) begin
                  state_d = S_IDLE;
               end
            end

            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Output holding register and overrun detection
   // -------------------------------------------------------------------------
   always_comb begin
      valid_d   = valid_q;
      dout_d    = dout_q;
      pe_d      = pe_q;
      fe_d      = fe_q;
      bi_d      = bi_q;
      overrun_d = 1'b0;

      if (complete) begin
         if (!valid_q || ready) begin
            valid_d = 1'b1;
            dout_d  = brk ? 8'h00 : data_q;
            pe_d    = pe_calc_q;
            fe_d    = !stop_bit || brk;
            bi_d    = brk;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q    <= '1;
         fill_q    <= '0;
         armed_q   <= 1'b0;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= 3'd0;
         samp_a_q  <= 1'b1;
         samp_b_q  <= 1'b1;
         data_q    <= 8'h00;
         par_bit_q <= 1'b0;
         pe_calc_q <= 1'b0;
         second_q  <= 1'b0;
         cfg_wls_q <= 2'b00;
         cfg_pen_q <= 1'b0;
         cfg_eps_q <= 1'b0;
         cfg_sp_q  <= 1'b0;
         cfg_stb_q <= 1'b0;
         valid_q   <= 1'b0;
         dout_q    <= 8'h00;
         pe_q      <= 1'b0;
         fe_q      <= 1'b0;
         bi_q      <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         fill_q    <= fill_d;
         armed_q   <= armed_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         samp_a_q  <= samp_a_d;
         samp_b_q  <= samp_b_d;
         data_q    <= data_d;
         par_bit_q <= par_bit_d;
         pe_calc_q <= pe_calc_d;
         second_q  <= second_d;
         cfg_wls_q <= cfg_wls_d;
         cfg_pen_q <= cfg_pen_d;
         cfg_eps_q <= cfg_eps_d;
         cfg_sp_q  <= cfg_sp_d;
         cfg_stb_q <= cfg_stb_d;
         valid_q   <= valid_d;
         dout_q    <= dout_d;
         pe_q      <= pe_d;
         fe_q      <= fe_d;
         bi_q      <= bi_d;
         overrun_q <= overrun_d;
      end
   end

   assign valid     = valid_q;
   assign dout      = dout_q;
   assign pe        = pe_q;
   assign fe        = fe_q;
   assign bi        = bi_q;
   assign overrun   = overrun_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
//
// Drives serial frames bit by bit (each bit lasts OS baud ticks) and predicts
// each frame's result from the framing rules alone: data masked to the word
// length, parity from a ones count, break when every sampled bit is zero.
// Predictions go into exp_q before the stop bit is sent; a monitor on the
// falling clock edge pops them as the receiver presents frames or overruns.
// Expected entry layout: {dropped, bi, fe, pe, dout[7:0]}.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

   localparam int OS   = 16;
   localparam int BDIV = 2;

   logic       clk;
   logic       rst;
   logic       baud_pulse;
   logic       rx;
   logic [1:0] wls;
   logic       pen;
   logic       eps;
   logic       sticky_parity;
   logic       stb;
   logic       ready;
   logic       valid;
   logic [7:0] dout;
   logic       pe;
   logic       fe;
   logic       bi;
   logic       overrun;
   logic [2:0] state_dbg;

   logic [11:0] exp_q[$];
   int          vectors;
   int          miscompares;
   int          phase;

   uart_rx_param #(
      .OVERSAMPLE (OS),
      .SYNC_STAGES(2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .baud_pulse   (baud_pulse),
      .rx           (rx),
      .wls          (wls),
      .pen          (pen),
      .eps          (eps),
      .sticky_parity(sticky_parity),
      .stb          (stb),
      .ready        (ready),
      .valid        (valid),
      .dout         (dout),
      .pe           (pe),
      .fe           (fe),
      .bi           (bi),
      .overrun      (overrun),
      .state_dbg    (state_dbg)
   );

   // ---------------------------------------------------------------- clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- checks
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- driver tasks
   // Inputs change 2 time units after the rising edge; baud_pulse is high for
   // one clk out of every BDIV.
   task automatic clk_step();
      @(posedge clk);
      #2;
      phase      = (phase + 1) % BDIV;
      baud_pulse = (phase == 0);
   endtask

   task automatic ticks(input int n);
      repeat (n * BDIV) clk_step();
   endtask

   // One bit period; glitch_at >= 0 inverts the line for that single tick.
   task automatic send_bit(input logic b, input int glitch_at);
      for (int t = 0; t < OS; t++) begin
         rx = (t == glitch_at) ? ~b : b;
         ticks(1);
      end
      rx = b;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic p,
                             input logic e, input logic s, input logic st,
                             input logic par_flip, input logic stop_val,
                             input logic drop, input int glitch_bit);
      int         nb;
      int         ones;
      logic [7:0] dm;
      logic       expp;
      logic       sent;
      logic       brk;
      wls           = w;
      pen           = p;
      eps           = e;
      sticky_parity = s;
      stb           = st;
      nb   = 5 + int'(w);
      dm   = d & (8'hFF >> (3 - int'(w)));
      ones = $countones(dm);
      if (s)      expp = ~e;
      else if (e) expp = (ones % 2 == 1);
      else        expp = (ones % 2 == 0);
      sent = expp ^ par_flip;
      brk  = (dm == 8'h00) && (!p || !sent) && !stop_val;
      send_bit(1'b0, -1);
      for (int i = 0; i < nb; i++) begin
         send_bit(dm[i], (i == glitch_bit) ? 9 : -1);
      end
      if (p) send_bit(sent, -1);
      exp_q.push_back({drop, brk, (!stop_val) | brk, p & par_flip, brk ? 8'h00 : dm});
      send_bit(stop_val, -1);
      if (st) send_bit(1'b1, -1);
      rx = 1'b1;
   endtask

   // ---------------------------------------------------------------- monitor
   initial begin : monitor
      logic [11:0] e;
      logic [10:0] held;
      logic [10:0] cur;
      logic        presented;
      logic        stable_ok;
      int          held_cyc;
      presented = 1'b0;
      stable_ok = 1'b1;
      held_cyc  = 0;
      held      = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            presented = 1'b0;
            continue;
         end
         cur = {bi, fe, pe, dout};
         if (overrun === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_overrun: got overrun=1, required no pending frame");
            end else begin
               e = exp_q.pop_front();
               if (!e[11]) begin
                  miscompares++;
                  $display("FAIL overrun: got frame dropped, required dout=%h loaded", e[7:0]);
               end
            end
         end
         if (presented && (valid !== 1'b1)) begin
            if (held_cyc > 0) begin
               vectors++;
               if (!stable_ok) begin
                  miscompares++;
                  $display("FAIL hold_stable: outputs changed while valid, required %h", held);
               end
            end
            presented = 1'b0;
         end
         if (valid === 1'b1) begin
            if (!presented) begin
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_frame: got {bi,fe,pe,dout}=%h, required no frame", cur);
               end else begin
                  e = exp_q.pop_front();
                  if ({1'b0, cur} !== e) begin
                     miscompares++;
                     $display("FAIL frame: got {drop,bi,fe,pe,dout}=%h, required %h", {1'b0, cur}, e);
                  end
               end
               presented = 1'b1;
               held      = cur;
               stable_ok = 1'b1;
               held_cyc  = 0;
            end else begin
               held_cyc++;
               if (cur !== held) stable_ok = 1'b0;
            end
            if (ready === 1'b1) begin
               if (held_cyc > 0) begin
                  vectors++;
                  if (!stable_ok) begin
                     miscompares++;
                     $display("FAIL hold_stable: outputs changed while valid, required %h", held);
                  end
               end
               presented = 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   initial begin : driver
      int waitc;
      vectors       = 0;
      miscompares   = 0;
      phase         = 0;
      rst           = 1'b0;
      baud_pulse    = 1'b0;
      rx            = 1'b1;
      wls           = 2'b11;
      pen           = 1'b0;
      eps           = 1'b0;
      sticky_parity = 1'b0;
      stb           = 1'b0;
      ready         = 1'b1;

      // Reset state
      repeat (4) clk_step();
      chk("reset_valid", {31'd0, valid}, 32'd0);
      chk("reset_dout", {24'd0, dout}, 32'd0);
      chk("reset_pe", {31'd0, pe}, 32'd0);
      chk("reset_fe", {31'd0, fe}, 32'd0);
      chk("reset_bi", {31'd0, bi}, 32'd0);
      chk("reset_overrun", {31'd0, overrun}, 32'd0);
      rst = 1'b1;
      ticks(8);

      // 8N1 0xA5
      send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      ticks(4);

      // 7E1 0x41 with wrong parity bit (1), then correct parity (0)
      send_frame(8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
      ticks(4);
      send_frame(8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      ticks(4);

      // False start: 5 ticks low, then a clean 8N1 0x3C
      rx = 1'b0;
      ticks(5);
      rx = 1'b1;
      ticks(24);
      chk("false_start_no_valid", {31'd0, valid}, 32'd0);
      send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      ticks(4);

      // Break: 12 bit times low on an 8N1 configuration
      wls = 2'b11; pen = 1'b0; stb = 1'b0;
      exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b0, 8'h00});
      rx = 1'b0;
      ticks(12 * OS);
      chk("break_reported_once_pending", exp_q.size(), 32'd0);
      rx = 1'b1;
      ticks(24);

      // Overrun: two frames with ready low
      ready = 1'b0;
      send_frame(8'h11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      ticks(4);
      send_frame(8'h22, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
      ticks(20);
      chk("overrun_held_dout", {24'd0, dout}, 32'h11);
      chk("overrun_held_valid", {31'd0, valid}, 32'd1);
      ready = 1'b1;
      clk_step();
      clk_step();
      chk("valid_clears_after_ready", {31'd0, valid}, 32'd0);
      ticks(4);

      // Single-tick glitch in the middle of data bit 3 of 0xFF
      send_frame(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);
      ticks(4);

      // Reset during DATA while a frame is held
      ready = 1'b0;
      send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      ticks(4);
      send_bit(1'b0, -1);
      send_bit(1'b1, -1);
      send_bit(1'b0, -1);
      send_bit(1'b1, -1);
      rx = 1'b0;
      ticks(8);
      rst = 1'b0;
      clk_step();
      chk("midreset_valid", {31'd0, valid}, 32'd0);
      chk("midreset_dout", {24'd0, dout}, 32'd0);
      chk("midreset_flags", {29'd0, pe, fe, bi}, 32'd0);
      chk("midreset_overrun", {31'd0, overrun}, 32'd0);
      rst   = 1'b1;
      ready = 1'b1;
      // Line still low after release: this must not be taken as a start.
      ticks(20);
      rx = 1'b1;
      ticks(24);
      chk("no_frame_after_reset", {31'd0, valid}, 32'd0);
      send_frame(8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      ticks(4);

      // Random frames
      for (int n = 0; n < 40; n++) begin
         logic [7:0] d;
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) d = 8'h00;
         send_frame(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 7) != 0), 1'b0, -1);
         ticks($urandom_range(2, 20));
      end

      // Drain with a bounded wait
      waitc = 0;
      while (exp_q.size() != 0 && waitc < 4000) begin
         clk_step();
         waitc++;
      end
      chk("drain_pending", exp_q.size(), 32'd0);
      ticks(40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
